spi_reg_master: RTL

SPI_REG_MASTER -- requirements
Module: spi_reg_master

---
 rtl/spi_reg_master_if.sv | 30 +++
 rtl/spi_reg_master.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_master_if.sv
// Command/response and SPI pin bundle for spi_reg_master. "slave" is the controller's view,
// "master" the surrounding system (requester and peripheral). data_ready only with SPIM_DATA_READY_EN.
interface spi_reg_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [1:0]  cmd_width;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        spi_cs_n;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
`ifdef SPIM_DATA_READY_EN
  logic        data_ready;

  modport master (output cmd_valid, cmd_rw, cmd_width, cmd_addr, cmd_wdata, spi_miso, data_ready,
                  input  cmd_ready, rsp_valid, rsp_rdata, busy, spi_cs_n, spi_clk, spi_mosi);
  modport slave  (input  cmd_valid, cmd_rw, cmd_width, cmd_addr, cmd_wdata, spi_miso, data_ready,
                  output cmd_ready, rsp_valid, rsp_rdata, busy, spi_cs_n, spi_clk, spi_mosi);
`else
  modport master (output cmd_valid, cmd_rw, cmd_width, cmd_addr, cmd_wdata, spi_miso,
                  input  cmd_ready, rsp_valid, rsp_rdata, busy, spi_cs_n, spi_clk, spi_mosi);
  modport slave  (input  cmd_valid, cmd_rw, cmd_width, cmd_addr, cmd_wdata, spi_miso,
                  output cmd_ready, rsp_valid, rsp_rdata, busy, spi_cs_n, spi_clk, spi_mosi);
`endif
endinterface

// File: rtl/spi_reg_master.sv
// SPI mode-0 register master: header {rw,5'b0,width},{2'b00,addr} then 8/16/32 data bits, MSB first.
// Optional SPIM_DATA_READY_EN: reads stall after the header until a synchronized data_ready.
module spi_reg_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  spi_reg_master_if.slave bus
);

`ifdef SPIM_DATA_READY_EN
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT_RDY, HOLD, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [5:0] HDR_BITS = 6'd16;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;      // bits fully clocked out so far
  logic [47:0] tx_q, tx_d;        // frame, current bit at [47]
  logic [31:0] rx_q, rx_d;
  logic        rw_q, rw_d;
  logic [1:0]  width_q, width_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [5:0]  nbits;
  logic        accept;
  logic        div_end;
`ifdef SPIM_DATA_READY_EN
  logic        rdy_s1_q, rdy_s1_d;
  logic        rdy_s2_q, rdy_s2_d;
`endif

  function automatic logic [47:0] load_frame(input logic rw, input logic [1:0] width,
                                             input logic [5:0] addr, input logic [31:0] wdata);
    logic [31:0] data;
    data = '0;
    if (rw) begin
      case (width)
        2'b00:   data = {wdata[7:0], 24'd0};
        2'b01:   data = {wdata[15:0], 16'd0};
        default: data = wdata;
      endcase
    end
    return {rw, 5'd0, width, 2'b00, addr, data};
  endfunction

  assign accept  = bus.cmd_valid && (state_q == IDLE) && !rst;
  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    case (width_q)
      2'b00:   nbits = 6'd24;
      2'b01:   nbits = 6'd32;
      default: nbits = 6'd48;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rw_d        = rw_q;
    width_d     = width_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
`ifdef SPIM_DATA_READY_EN
    rdy_s1_d    = bus.data_ready;
    rdy_s2_d    = rdy_s1_q;
`endif

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (accept) begin
          state_d = SETUP;
          div_d   = '0;
          bit_d   = '0;
          rw_d    = bus.cmd_rw;
          width_d = bus.cmd_width;
          tx_d    = load_frame(bus.cmd_rw, bus.cmd_width, bus.cmd_addr, bus.cmd_wdata);
          rx_d    = '0;
          cs_n_d  = 1'b0;
          mosi_d  = bus.cmd_rw;
        end
      end

      SETUP: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          state_d = SHIFT;
          div_d   = '0;
          sclk_d  = 1'b1;
        end
      end

      SHIFT: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          div_d = '0;
          if (sclk_q) begin
            // falling edge: present the next frame bit
            sclk_d = 1'b0;
            tx_d   = tx_q << 1;
            mosi_d = tx_q[46];
          end else begin
            bit_d = bit_q + 6'd1;
            if (bit_d == nbits) begin
              state_d = HOLD;
`ifdef SPIM_DATA_READY_EN
            end else if (bit_d == HDR_BITS && !rw_q) begin
              state_d = WAIT_RDY;
`endif
            end else begin
              sclk_d = 1'b1;
              if (bit_d >= HDR_BITS) rx_d = {rx_q[30:0], bus.spi_miso};
            end
          end
        end
      end

`ifdef SPIM_DATA_READY_EN
      WAIT_RDY: begin
        if (rdy_s2_q) begin
          state_d = SHIFT;
          div_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[30:0], bus.spi_miso};
        end
      end
`endif

      HOLD: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          state_d     = GAP;
          div_d       = '0;
          cs_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rdata_d     = rw_q ? 32'd0 : rx_q;
        end
      end

      GAP: begin
        div_d = div_q + 8'd1;
        if (div_q == GAP_LAST) begin
          state_d = IDLE;
          div_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rw_q        <= 1'b0;
      width_q     <= 2'b00;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
`ifdef SPIM_DATA_READY_EN
      rdy_s1_q    <= 1'b0;
      rdy_s2_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      width_q     <= width_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
`ifdef SPIM_DATA_READY_EN
      rdy_s1_q    <= rdy_s1_d;
      rdy_s2_q    <= rdy_s2_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.spi_cs_n  = cs_n_q;
  assign bus.spi_clk   = sclk_q;
  assign bus.spi_mosi  = mosi_q;

endmodule
